// File: rtl/music_tone_player_if.sv
// Read-side link between the tone player and the music memory.
interface music_tone_player_if #(
    parameter int unsigned DATA_WIDTH = 10
);
    logic                  read_en;
    logic                  read_rst;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (
        output read_en,
        output read_rst,
        input  data,
        input  ready
    );

    modport slave (
        input  read_en,
        input  read_rst,
        output data,
        output ready
    );
endinterface

// File: rtl/music_tone_player.sv
// Plays the stored song: walks the music memory, decodes note words and drives a square-wave buzzer.
// state    | meaning
// IDLE     | stopped, memory rewound, no tone
// PLAY     | reading memory and sounding the latched note
// PAUSE    | read and tone halted, read position kept
// DONE     | song ended without loop, waiting for play
module music_tone_player #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  loop_en,
    music_tone_player_if.master   mem,
    output logic                  buzzer,
    output logic [DATA_WIDTH-1:0] cur_note,
    output logic                  playing,
    output logic                  song_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam int unsigned HC_C = CLK_FREQ / (2 * 262);
    localparam int unsigned HC_D = CLK_FREQ / (2 * 294);
    localparam int unsigned HC_E = CLK_FREQ / (2 * 330);
    localparam int unsigned HC_F = CLK_FREQ / (2 * 349);
    localparam int unsigned HC_G = CLK_FREQ / (2 * 392);
    localparam int unsigned HC_A = CLK_FREQ / (2 * 440);
    localparam int unsigned HC_B = CLK_FREQ / (2 * 494);

    state_t                state_q;
    state_t                state_d;
    logic                  rewind;
    logic                  rd_rst_q;
    logic                  seen_ready;
    logic [DATA_WIDTH-1:0] cur_note_q;
    logic                  note_take;
    logic                  note_load;
    logic [CNT_WIDTH-1:0]  base_half;
    logic [CNT_WIDTH-1:0]  half;
    logic                  is_rest;
    logic                  tone_en;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  buz_q;

    assign note_take = (state_q == ST_PLAY) && mem.ready;
    assign note_load = note_take && (mem.data != cur_note_q);

    always_comb begin
        state_d = state_q;
        rewind  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            rewind  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play && !pause) begin
                        state_d = ST_PLAY;
                        rewind  = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (seen_ready && !mem.ready) begin
                        if (loop_en) begin
                            rewind = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play && !pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // seen_ready masks the memory's ready latency after a rewind from end-of-song detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_rst_q   <= 1'b0;
            seen_ready <= 1'b0;
            cur_note_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_rst_q <= rewind;
            if (rewind) begin
                seen_ready <= 1'b0;
            end else if (note_take) begin
                seen_ready <= 1'b1;
            end
            if (note_take) begin
                cur_note_q <= mem.data;
            end
        end
    end

    // Lowest set pitch bit wins when several are set
    always_comb begin
        base_half = '0;
        is_rest   = 1'b0;
        if (cur_note_q[2]) begin
            base_half = CNT_WIDTH'(HC_C);
        end else if (cur_note_q[3]) begin
            base_half = CNT_WIDTH'(HC_D);
        end else if (cur_note_q[4]) begin
            base_half = CNT_WIDTH'(HC_E);
        end else if (cur_note_q[5]) begin
            base_half = CNT_WIDTH'(HC_F);
        end else if (cur_note_q[6]) begin
            base_half = CNT_WIDTH'(HC_G);
        end else if (cur_note_q[7]) begin
            base_half = CNT_WIDTH'(HC_A);
        end else if (cur_note_q[8]) begin
            base_half = CNT_WIDTH'(HC_B);
        end else begin
            is_rest = 1'b1;
        end
    end

    always_comb begin
        half = base_half;
        case (cur_note_q[1:0])
            2'b01:   half = base_half >> 1;
            2'b10:   half = base_half << 1;
            default: half = base_half;
        endcase
    end

    assign tone_en = (state_q == ST_PLAY) && seen_ready && !is_rest;

    // A new note word restarts the period so a shorter period is never overshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buz_q <= 1'b0;
        end else if (!tone_en || note_load) begin
            cnt_q <= '0;
            buz_q <= 1'b0;
        end else if (cnt_q == half - 1'b1) begin
            cnt_q <= '0;
            buz_q <= ~buz_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign buzzer       = buz_q & tone_en;
    assign cur_note     = cur_note_q;
    assign playing      = (state_q == ST_PLAY);
    assign song_done    = (state_q == ST_DONE);
    assign mem.read_en  = (state_q == ST_PLAY) && !rd_rst_q;
    assign mem.read_rst = rd_rst_q;

endmodule
